// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encodings, oversampling factor
// and a constant-evaluable clog2 used to size counters.
package uart_rx_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int NB_DATA_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both stages
// reset to RESET_VAL so an idle-high line does not look like a start edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: centre-samples start, data (LSB first) and
// stop bits, emitting a one-cycle done pulse with framing-error status.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int SB_TICK = OVERSAMPLE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic [1:0]         o_dbg_state
);

  // One tick counter serves all states, so it must be wide enough for STOP.
  localparam int TW_STOP = clog2(SB_TICK);
  localparam int TW      = (TW_STOP > 4) ? TW_STOP : 4;
  localparam int BW      = (clog2(NB_DATA) > 0) ? clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  logic               w_rx_s;
  logic [1:0]         r_state;
  logic               r_armed;
  logic [TW-1:0]      r_tick_cnt;
  logic [BW-1:0]      r_bit_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic [NB_DATA-1:0] r_data;
  logic               r_done;
  logic               r_ferr;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // A break leaves armed cleared, so the line must go high before
        // another start edge is accepted.
        ST_IDLE: begin
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: if (i_tick) begin
          if (r_tick_cnt == TICK_MID) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        ST_DATA: if (i_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            r_shift    <= {w_rx_s, r_shift[NB_DATA-1:1]};
            r_tick_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) r_state <= ST_STOP;
            else                       r_bit_cnt <= r_bit_cnt + BW'(1);
          end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        ST_STOP: if (i_tick) begin
          if (r_tick_cnt == STOP_LAST) begin
            r_data     <= r_shift;
            r_ferr     <= ~w_rx_s;
            r_done     <= 1'b1;
            r_tick_cnt <= '0;
            r_state    <= ST_IDLE;
            if (!w_rx_s) r_armed <= 1'b0;
          end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_data   = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_ferr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal serial driver (160 clk/bit, tick every 10 clk),
// expected queue of {frame_err, data} built from the bytes and stop bits sent.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_PER_TICK = 10;
  localparam int CLK_PER_BIT  = 160;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_tick  = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic [1:0] o_dbg_state;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  int          long_pulses = 0;
  logic        prev_done   = 1'b0;

  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  int unsigned got_cyc_q[$];

  uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_rx_data   (o_rx_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / tick ----------------
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin : tick_gen
    int n;
    n = 0;
    forever begin
      @(posedge i_clk);
      #1;
      i_tick = (n == CLK_PER_TICK - 1);
      n = (n == CLK_PER_TICK - 1) ? 0 : n + 1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (o_rx_done) begin
      got_q.push_back({o_frame_err, o_rx_data});
      got_cyc_q.push_back(cyc);
    end
    if (o_rx_done && prev_done) long_pulses++;
    prev_done = o_rx_done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level; the caller restores idle after a break.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            output int unsigned edge_cyc);
    exp_q.push_back({~stop_b, d});
    edge_cyc = cyc;
    i_rx = 1'b0;
    wait_clk(CLK_PER_BIT);
    for (int k = 0; k < 8; k++) begin
      i_rx = d[k];
      wait_clk(CLK_PER_BIT);
    end
    i_rx = stop_b;
    wait_clk(CLK_PER_BIT);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    wait_clk(5);
    i_reset = 1'b0;
    wait_clk(2);
    vectors++;
    if ({o_rx_data, o_rx_done, o_frame_err, o_dbg_state} !== {8'h00, 1'b0, 1'b0, ST_IDLE}) begin
      miscompares++;
      $display("FAIL reset_values: got data=%h done=%b err=%b st=%0d, want 00 0 0 %0d",
               o_rx_data, o_rx_done, o_frame_err, o_dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_basic();
    int unsigned ec;
    int unsigned dt;
    logic [8:0] e, g;
    send_frame(8'hA5, 1'b1, ec);
    wait_clk(20);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d pulses, want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); dt = got_cyc_q.pop_front() - ec;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL basic_data: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
      vectors++;
      if (dt < 1510 || dt > 1530) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d clk after start edge, want 1510..1530", dt);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_glitch();
    int unsigned ec;
    logic [8:0] e, g;
    i_rx = 1'b0;
    wait_clk(40);
    i_rx = 1'b1;
    wait_clk(300);
    vectors++;
    if (got_q.size() != 0 || o_dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL glitch_reject: got %0d pulses st=%0d, want 0 pulses st=%0d",
               got_q.size(), o_dbg_state, ST_IDLE);
    end
    send_frame(8'h3C, 1'b1, ec);
    wait_clk(20);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL glitch_count: got %0d pulses, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL glitch_next_frame: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_break();
    int unsigned ec;
    logic [8:0] e, g;
    send_frame(8'h3C, 1'b0, ec);
    wait_clk(3 * CLK_PER_BIT);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL break_count: got %0d pulses, want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL break_frame: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    vectors++;
    if ({o_frame_err, o_rx_data} !== {1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL break_hold: got err=%b data=%h, want 1 3c", o_frame_err, o_rx_data);
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    i_rx = 1'b1;
    wait_clk(CLK_PER_BIT);
    send_frame(8'h81, 1'b1, ec);
    wait_clk(20);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL break_recover_count: got %0d pulses, want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL break_recover: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    int unsigned ec;
    logic [8:0] e, g;
    send_frame(8'h00, 1'b1, ec);
    send_frame(8'hFF, 1'b1, ec);
    wait_clk(20);
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses, want 2", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL b2b_frame: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int unsigned ec;
    logic [7:0] d;
    logic [8:0] e, g;
    d = 8'h96;
    i_rx = 1'b0;
    wait_clk(CLK_PER_BIT);
    for (int k = 0; k < 4; k++) begin
      i_rx = d[k];
      wait_clk(CLK_PER_BIT);
    end
    i_rx = d[4];
    wait_clk(CLK_PER_BIT / 2);
    i_reset = 1'b1;
    wait_clk(1);
    i_reset = 1'b0;
    i_rx = 1'b1;
    wait_clk(2 * CLK_PER_BIT);
    vectors++;
    if (got_q.size() != 0 || {o_rx_data, o_frame_err, o_dbg_state} !== {8'h00, 1'b0, ST_IDLE}) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d pulses data=%h err=%b st=%0d, want 0 00 0 %0d",
               got_q.size(), o_rx_data, o_frame_err, o_dbg_state, ST_IDLE);
    end
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'h55, 1'b1, ec);
    wait_clk(20);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL reset_next_count: got %0d pulses, want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_next_frame: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_random_stream();
    int unsigned ec;
    logic [7:0] d;
    logic       sb;
    logic [8:0] e, g;
    int         n_exp;
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, sb, ec);
      i_rx = 1'b1;
      if (!sb) wait_clk(CLK_PER_BIT + $urandom_range(0, 40));
      else     wait_clk($urandom_range(0, 40));
    end
    wait_clk(20);
    n_exp = exp_q.size();
    vectors++;
    if (got_q.size() != n_exp) begin
      miscompares++;
      $display("FAIL random_count: got %0d pulses, want %0d", got_q.size(), n_exp);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL random_frame: got err=%b data=%h, want err=%b data=%h", g[8], g[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_pulse_width();
    vectors++;
    if (long_pulses != 0) begin
      miscompares++;
      $display("FAIL done_pulse_width: got %0d multi-cycle pulses, want 0", long_pulses);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_stream();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
